// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port memory: RD/WAIT/WR per word, one-cycle read latency.
// Optional MEMCPY_FILL_EN adds a constant-fill mode that writes one word per cycle.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module mem_copy_engine #(
  parameter int AW = `ISIZE,
  parameter int DW = `DSIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
`ifdef MEMCPY_FILL_EN
  input  logic          fill_en,
  input  logic [DW-1:0] fill_data,
`endif
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic          mem_read,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] count_q, count_d;
  logic [DW-1:0] data_q, data_d;
  logic          fill_q, fill_d;
  logic          start_fill;
  logic [DW-1:0] start_data;

`ifdef MEMCPY_FILL_EN
  assign start_fill = fill_en;
  assign start_data = fill_data;
`else
  assign start_fill = 1'b0;
  assign start_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    data_d  = data_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len;
          count_d = '0;
          fill_d  = start_fill;
          if (start_fill) data_d = start_data;
          if (len == '0)      state_d = S_DONE;
          else if (start_fill) state_d = S_WR;
          else                state_d = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        data_d  = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        // The write in this cycle commits even if abort is also high.
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        rem_d   = rem_q - AW'(1);
        count_d = count_q + AW'(1);
        if (rem_q == AW'(1)) state_d = S_DONE;
        else if (fill_q)     state_d = S_WR;
        else                 state_d = S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_read  = (state_q == S_RD) || (state_q == S_WAIT);
  assign mem_wen   = (state_q == S_WR);
  assign mem_addr  = (state_q == S_WR) ? dst_q : src_q;
  assign mem_wdata = data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a registered-address single-port memory model.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
  logic        abort = 1'b0;
  logic        busy, done, mem_read, mem_wen;
  logic [15:0] count, mem_addr, mem_wdata, mem_rdata;
`ifdef MEMCPY_FILL_EN
  logic        fill_en = 1'b0;
  logic [15:0] fill_data = '0;
`endif

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEMCPY_FILL_EN
    .fill_en(fill_en), .fill_data(fill_data),
`endif
    .abort(abort), .busy(busy), .done(done), .count(count),
    .mem_read(mem_read), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] raddr_q = '0;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_read) raddr_q <= mem_addr;
  end
  assign mem_rdata = mem[raddr_q];

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int busy_cnt, done_cnt, done_cyc, acc_cnt, rd_n, wr_n;
  logic [15:0] rd_log [0:15];
  logic [15:0] wr_log [0:15];
  logic prev_rd = 1'b0;

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; acc_cnt = 0; rd_n = 0; wr_n = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = busy_cnt; end
      if (mem_read || mem_wen) acc_cnt++;
      if (mem_read && !prev_rd && rd_n < 16) begin rd_log[rd_n] = mem_addr; rd_n++; end
      if (mem_wen && wr_n < 16) begin wr_log[wr_n] = mem_addr; wr_n++; end
    end
    prev_rd = mem_read;
  end

  // abort_at: abort during the WR cycle where count equals this value (-1 = never).
  task automatic xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                      input int abort_at, input logic start_abort, input logic extra_start,
                      input logic f_en, input logic [15:0] f_data);
    bit finished = 0;
    @(negedge clk);
    clear_mon();
    src_addr = s; dst_addr = d; len = l; start = 1'b1; abort = start_abort;
`ifdef MEMCPY_FILL_EN
    fill_en = f_en; fill_data = f_data;
`else
    if (f_en) $display("note: fill requested without fill build, data %0h", f_data);
`endif
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      if (extra_start && i == 2) begin
        src_addr = 16'h0080; dst_addr = 16'h0070; len = 16'h0001; start = 1'b1;
      end
      if (abort_at >= 0 && mem_wen && count == 16'(abort_at)) abort = 1'b1;
      if (!busy) begin finished = 1; break; end
    end
    start = 1'b0; abort = 1'b0;
    if (!finished) check("xfer_timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'hDEAD;
    mem[16'h10] = 16'h00A1; mem[16'h11] = 16'h00B2; mem[16'h12] = 16'h00C3; mem[16'h13] = 16'h00D4;
    mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222; mem[16'h0000] = 16'h3333;
    for (int i = 0; i < 8; i++) mem[16'h200 + i] = 16'h7000 + 16'(i);

    #12;
    check("reset_outputs", {busy, done, mem_read, mem_wen, mem_addr, mem_wdata, count}, 0);
    @(negedge clk);
    rst = 1'b1;

    // basic copy
    xfer(16'h10, 16'h40, 16'd4, -1, 0, 0, 0, 0);
    check("basic_busy_cycles", busy_cnt, 13);
    check("basic_done_cycle", done_cyc, 13);
    check("basic_done_count", done_cnt, 1);
    check("basic_count", count, 4);
    check("basic_mem", {mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]},
          64'h00A1_00B2_00C3_00D4);
    check("basic_no_overrun", mem[16'h44], 16'hDEAD);

    // zero length, with abort alongside start (start wins)
    xfer(16'h10, 16'h48, 16'd0, -1, 1, 0, 0, 0);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_done_cycle", done_cyc, 1);
    check("zero_no_access", acc_cnt, 0);
    check("zero_count", count, 0);

    // wrap-around source
    xfer(16'hFFFE, 16'h0100, 16'd3, -1, 0, 0, 0, 0);
    check("wrap_reads", {rd_log[0], rd_log[1], rd_log[2]}, 48'hFFFE_FFFF_0000);
    check("wrap_read_count", rd_n, 3);
    check("wrap_writes", {wr_log[0], wr_log[1], wr_log[2]}, 48'h0100_0101_0102);
    check("wrap_mem", {mem[16'h100], mem[16'h101], mem[16'h102]}, 48'h1111_2222_3333);

    // abort during WR of the third word
    xfer(16'h200, 16'h300, 16'd8, 2, 0, 0, 0, 0);
    check("abort_count", count, 3);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);
    check("abort_mem_copied", {mem[16'h300], mem[16'h301], mem[16'h302]}, 48'h7000_7001_7002);
    check("abort_mem_untouched", {mem[16'h303], mem[16'h307]}, 32'hDEAD_DEAD);

    // start while busy is ignored
    xfer(16'h10, 16'h60, 16'd2, -1, 0, 1, 0, 0);
    check("ignored_start_reads", {rd_log[0], rd_log[1]}, 32'h0010_0011);
    check("ignored_start_read_count", rd_n, 2);
    check("ignored_start_mem", {mem[16'h60], mem[16'h61]}, 32'h00A1_00B2);
    check("ignored_start_no_write", mem[16'h70], 16'hDEAD);
    check("ignored_start_count", count, 2);

    // asynchronous reset during WAIT
    @(negedge clk);
    clear_mon();
    src_addr = 16'h10; dst_addr = 16'h50; len = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_in_rd_read", mem_read, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst_async_outputs", {busy, done, mem_read, mem_wen, mem_addr, mem_wdata, count}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_write", mem[16'h50], 16'hDEAD);
    check("rst_stays_idle", busy, 0);

`ifdef MEMCPY_FILL_EN
    xfer(16'h10, 16'h20, 16'd5, -1, 0, 0, 1, 16'h5A5A);
    fill_en = 1'b0;
    check("fill_busy_cycles", busy_cnt, 6);
    check("fill_no_read", rd_n, 0);
    check("fill_mem", {mem[16'h20], mem[16'h22], mem[16'h24]}, 48'h5A5A_5A5A_5A5A);
    check("fill_count", count, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-transfer initiator that drives the single-port instruction/data memory from the requester side. Given a source address, destination address and word count, it issues read cycles and honours the memory's one-cycle registered-address read latency. Each returned word is then written to the destination range. Used at reset/debug time to relocate program images and initialise data memory without involving the pipeline.

## Interface
- `AW`, default `` `ISIZE `` (16): address and length width.
- `DW`, default `` `DSIZE `` (16): data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, **active-low**.
- `start`  in  1  request pulse; accepted only in IDLE.
- `src_addr`  in  AW  first source word address; sampled on accepted `start`.
- `dst_addr`  in  AW  first destination word address; sampled on accepted `start`.
- `len`  in  AW  number of words; sampled on accepted `start`.
- `abort`  in  1  synchronous cancel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `count`  out  AW  words written so far in the current or last transfer.
- `mem_read`  out  1  to memory `mem_read`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_wdata`  out  DW  to memory `data_in`.
- `mem_rdata`  in  DW  from memory `data_out`.

## Operation
- States: IDLE, RD, WAIT, WR, DONE.
- **IDLE**
  - All memory strobes are low.
  - `start`=1 latches `src_addr`, `dst_addr` and `len` into `src_r`, `dst_r` and `rem_r`, and clears `count`.
  - Next state is RD if `len`≠0, otherwise DONE.
- **RD**
  - Drives `mem_addr`=`src_r`, `mem_read`=1.
  - Next state is WAIT.
- **WAIT**
  - Holds `mem_read`=1 and `mem_addr`=`src_r`.
  - Captures `mem_rdata` into `data_r` at the closing edge.
  - Next state is WR.
- **WR**
  - Drives `mem_addr`=`dst_r`, `mem_wdata`=`data_r`, `mem_wen`=1, `mem_read`=0.
  - At the closing edge: `src_r`+1, `dst_r`+1, `rem_r`−1, `count`+1.
  - Next state is RD if `rem_r`≠1, else DONE.
- **DONE**
  - Asserts `done`=1 for exactly one cycle, with `busy` still 1.
  - Next state is IDLE.
- Address arithmetic is modulo 2^AW; 0xFFFF+1 wraps to 0x0000.
- Words are copied in ascending order.
  - Overlapping ranges with dst>src propagate already-copied words; this is the defined behaviour.
- `abort`=1 in any non-IDLE state sends the FSM to IDLE at the next edge, with no `done` pulse.
  - A write whose `mem_wen` is high in that same cycle still commits.
  - `count` holds the number of words committed.
- `start` while `busy` is ignored.
- `start` together with `abort` in IDLE: `start` wins.

## Timing
- Reset (`rst`=0, asynchronous):
  - state IDLE.
  - `busy`, `done`, `mem_read`, `mem_wen` = 0.
  - `mem_addr`, `mem_wdata`, `count` = 0.
  - Internal registers = 0.
- Reset asserted mid-transfer aborts immediately; there is no partial write beyond the last completed WR edge.
- Outputs are registered from state/datapath flops. There is no combinational path from `mem_rdata` to any output.
- Per-word cost is 3 cycles (RD, WAIT, WR). A transfer of N≥1 words is `busy` for 3N+1 cycles, with `done` in the last of them.
- `len`=0: `busy` for 1 cycle (DONE), `done` pulses, and there is no memory access.
- The cycle after `start` is the first RD cycle; the next `start` can be accepted in the cycle after DONE.

## Configuration
- `MEMCPY_FILL_EN` defined:
  - Adds inputs `fill_en` (1) and `fill_data` (DW), both sampled with `start`.
  - If `fill_en`=1, the transfer skips RD/WAIT and loops WR→WR, writing `fill_data` to `dst`…`dst`+`len`−1.
  - One word per cycle; `busy` for N+1 cycles.
  - `src_addr` is ignored in fill mode.
- `MEMCPY_FILL_EN` undefined: those ports do not exist and every transfer is a copy.

## Test plan
- **Basic copy:** preload mem[0x10..0x13]=A1,B2,C3,D4; `start` with src=0x10, dst=0x40, len=4 → mem[0x40..0x43]=A1,B2,C3,D4; `busy` high 13 cycles; `done` in cycle 13; `count`=4.
- **Zero length:** `start` with len=0 → no `mem_read`/`mem_wen` ever high; `done` pulses the cycle after `start`; `count`=0.
- **Wrap-around:** `start` with src=0xFFFE, dst=0x0100, len=3 → reads 0xFFFE, 0xFFFF, 0x0000 in order; writes 0x0100..0x0102.
- **Abort:** `start` with len=8; assert `abort` during the WR cycle of word 3 → that write commits; `count`=3 then FSM in IDLE; no `done`; mem[dst+3..] unchanged.
- **Reset and ignored start:**
  - Assert `rst`=0 in the middle of WAIT → all outputs 0 asynchronously.
  - A second `start` pulsed while busy has no effect on the addresses used.
- **Fill (with `MEMCPY_FILL_EN`):** fill_en=1, fill_data=0x5A5A, dst=0x20, len=5 → mem[0x20..0x24]=0x5A5A; `mem_read` never high; `busy` 6 cycles.
